// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART TX round-robin arbiter.
package uart_arb_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    BUSY   = 2'd2,
    HOLD   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search. Returns the first set request
// strictly above ptr, wrapping modulo NUM_REQ; ptr itself is checked last.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner_oh,
  output logic [IDX_W-1:0]   winner_idx,
  output logic               any_valid
);

  logic [IDX_W-1:0] cand;

  // base + off never exceeds 2*NUM_REQ-1, so one subtraction wraps it
  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction

  // Scan upward from ptr+1 and keep the first requester found
  always_comb begin
    winner_oh  = '0;
    winner_idx = '0;
    any_valid  = 1'b0;
    cand       = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = wrap_idx(ptr, off);
      if (!any_valid && req[cand]) begin
        any_valid       = 1'b1;
        winner_idx      = cand;
        winner_oh[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART TX controller between NUM_REQ byte
// requesters with round-robin arbitration, one byte in flight at a time.
// Optional feature macro: UART_TX_ARB_PKT_LOCK_EN keeps the grant on one
// requester until a byte flagged Last has been transmitted.
//
// state  | meaning
// IDLE   | no owner; arbitrate among valid requesters
// LAUNCH | byte latched, o_Tx_Ready high until TX reports Active
// BUSY   | frame shifting, waiting for Done
// HOLD   | packet lock: waiting for the owner's next byte (lock build only)
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_REQ-1:0]             i_Req_Valid,
  input  logic [NUM_REQ*UART_DATA_W-1:0] i_Req_Byte,
  input  logic [NUM_REQ-1:0]             i_Req_Last,
  output logic [NUM_REQ-1:0]             o_Req_Ack,
  output logic [NUM_REQ-1:0]             o_Grant,
  output logic [UART_DATA_W-1:0]         o_Tx_Byte,
  output logic                           o_Tx_Ready,
  input  logic                           i_Tx_Active,
  input  logic                           i_Tx_Done,
  output logic                           o_Busy
);

  arb_state_t             state_q, state_nx;
  logic [IDX_W-1:0]       ptr_q, ptr_nx;
  logic [NUM_REQ-1:0]     grant_nx, ack_nx;
  logic [UART_DATA_W-1:0] byte_nx;

  logic [NUM_REQ-1:0]     pick_oh;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_any;

`ifdef UART_TX_ARB_PKT_LOCK_EN
  logic last_q, last_nx;
`else
  // Last flags only matter when packet lock is compiled in
  logic unused_last;
  assign unused_last = ^i_Req_Last;
`endif

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req        (i_Req_Valid),
    .ptr        (ptr_q),
    .winner_oh  (pick_oh),
    .winner_idx (pick_idx),
    .any_valid  (pick_any)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_nx;
  end

  // Next-state logic; Done is ignored until Active has moved us to BUSY
  always_comb begin
    state_nx = state_q;
    case (state_q)
      IDLE:   if (pick_any) state_nx = LAUNCH;
      LAUNCH: if (i_Tx_Active) state_nx = BUSY;
      BUSY: begin
        if (i_Tx_Done) begin
`ifdef UART_TX_ARB_PKT_LOCK_EN
          state_nx = last_q ? IDLE : HOLD;
`else
          state_nx = IDLE;
`endif
        end
      end
      HOLD: begin
`ifdef UART_TX_ARB_PKT_LOCK_EN
        if (i_Req_Valid[ptr_q]) state_nx = LAUNCH;
`else
        state_nx = IDLE;
`endif
      end
      default: state_nx = IDLE;
    endcase
  end

  // Next values of the registered outputs, pointer and lock flag
  always_comb begin
    ptr_nx   = ptr_q;
    grant_nx = o_Grant;
    ack_nx   = '0;
    byte_nx  = o_Tx_Byte;
`ifdef UART_TX_ARB_PKT_LOCK_EN
    last_nx  = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          ptr_nx   = pick_idx;
          grant_nx = pick_oh;
          ack_nx   = pick_oh;
          byte_nx  = i_Req_Byte[int'(pick_idx)*UART_DATA_W +: UART_DATA_W];
`ifdef UART_TX_ARB_PKT_LOCK_EN
          last_nx  = i_Req_Last[pick_idx];
`endif
        end
      end
      BUSY: begin
        if (i_Tx_Done && (state_nx == IDLE)) grant_nx = '0;
      end
      HOLD: begin
`ifdef UART_TX_ARB_PKT_LOCK_EN
        if (i_Req_Valid[ptr_q]) begin
          ack_nx  = o_Grant;
          byte_nx = i_Req_Byte[int'(ptr_q)*UART_DATA_W +: UART_DATA_W];
          last_nx = i_Req_Last[ptr_q];
        end
`endif
      end
      default: ;
    endcase
  end

  // Output and datapath registers; ptr resets so requester 0 is served first
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q      <= IDX_W'(NUM_REQ - 1);
      o_Grant    <= '0;
      o_Req_Ack  <= '0;
      o_Tx_Byte  <= '0;
      o_Tx_Ready <= 1'b0;
      o_Busy     <= 1'b0;
`ifdef UART_TX_ARB_PKT_LOCK_EN
      last_q     <= 1'b0;
`endif
    end else begin
      ptr_q      <= ptr_nx;
      o_Grant    <= grant_nx;
      o_Req_Ack  <= ack_nx;
      o_Tx_Byte  <= byte_nx;
      o_Tx_Ready <= (state_nx == LAUNCH);
      o_Busy     <= (state_nx != IDLE);
`ifdef UART_TX_ARB_PKT_LOCK_EN
      last_q     <= last_nx;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (NUM_REQ = 4). Works in both the
// default build and with UART_TX_ARB_PKT_LOCK_EN defined.
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req_valid, req_last, ack, grant;
  logic [N*8-1:0] req_byte;
  logic [7:0]     tx_byte;
  logic           tx_ready, tx_active, tx_done, busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_Req_Valid (req_valid),
    .i_Req_Byte  (req_byte),
    .i_Req_Last  (req_last),
    .o_Req_Ack   (ack),
    .o_Grant     (grant),
    .o_Tx_Byte   (tx_byte),
    .o_Tx_Ready  (tx_ready),
    .i_Tx_Active (tx_active),
    .i_Tx_Done   (tx_done),
    .o_Busy      (busy)
  );

  // per-requester pending bytes: {last, byte}
  logic [8:0] q [N][$];
  int         obs_req[$];
  logic [7:0] obs_byte[$];
  int         exp_req[$];
  logic [7:0] exp_byte[$];
  logic [7:0] rb [N];

  typedef struct {
    int         prev;
    logic [3:0] mask;
    logic [3:0] exp_grant;
    logic [7:0] exp_byte;
  } vec_t;
  vec_t tbl [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int oh2idx(input logic [N-1:0] v);
    int r = -1;
    int c = 0;
    for (int i = 0; i < N; i++) if (v[i]) begin r = i; c++; end
    if (c != 1) r = -1;
    return r;
  endfunction

  task automatic present(input int k);
    if (q[k].size() > 0) begin
      req_valid[k]       = 1'b1;
      req_byte[k*8 +: 8] = q[k][0][7:0];
      req_last[k]        = q[k][0][8];
    end else begin
      req_valid[k] = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    req_valid = '0;
    req_byte  = '0;
    req_last  = '0;
    tx_active = 1'b0;
    tx_done   = 1'b0;
    for (int k = 0; k < N; k++) q[k].delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    check("reset_vals", {ack, grant, tx_byte, tx_ready, busy}, '0);
  endtask

  // Requesters drain their queues while a TX controller stand-in answers
  // each launch with random Active delay and frame length.
  task automatic run_engine(input int nexp, input int budget);
    int phase = 0;
    int dly = 0;
    int len = 0;
    int cyc = 0;
    logic [7:0] inflight = '0;
    obs_req.delete();
    obs_byte.delete();
    for (int k = 0; k < N; k++) present(k);
    while ((obs_req.size() < nexp || phase != 0) && cyc < budget) begin
      step();
      cyc++;
      for (int k = 0; k < N; k++) begin
        if (ack[k]) begin
          check("ack_valid", {31'd0, req_valid[k]}, 32'd1);
          if (q[k].size() > 0) begin
            check("latch_byte", {24'd0, tx_byte}, {24'd0, q[k][0][7:0]});
            void'(q[k].pop_front());
          end else begin
            tests++;
            fails++;
            $display("FAIL ack_extra req=%0d actual=ack required=no_ack", k);
          end
          present(k);
        end
      end
      case (phase)
        0: if (tx_ready) begin dly = $urandom_range(0, 2); phase = 3; end
        3: begin
          if (dly > 0) dly--;
          else begin
            tx_active = 1'b1;
            inflight  = tx_byte;
            obs_req.push_back(oh2idx(grant));
            obs_byte.push_back(tx_byte);
            len   = $urandom_range(1, 4);
            phase = 1;
          end
        end
        1: begin
          check("ready_drop", {31'd0, tx_ready}, 32'd0);
          check("byte_hold", {24'd0, tx_byte}, {24'd0, inflight});
          len--;
          if (len == 0) begin
            tx_active = 1'b0;
            tx_done   = 1'b1;
            phase     = 2;
          end
        end
        default: begin
          tx_done = 1'b0;
          phase   = 0;
        end
      endcase
    end
    if (cyc >= budget) begin
      tests++;
      fails++;
      $display("FAIL engine_timeout actual=%0d_bytes required=%0d_bytes", obs_req.size(), nexp);
      tx_active = 1'b0;
      tx_done   = 1'b0;
    end
  endtask

  task automatic compare_lists(input string name);
    int n;
    check({name, "_count"}, obs_req.size(), exp_req.size());
    n = (obs_req.size() < exp_req.size()) ? obs_req.size() : exp_req.size();
    for (int i = 0; i < n; i++) begin
      check({name, "_req"}, obs_req[i], exp_req[i]);
      check({name, "_byte"}, {24'd0, obs_byte[i]}, {24'd0, exp_byte[i]});
    end
  endtask

  // Reference order: serve the nearest non-empty queue above the previous
  // winner; with lock, drain that queue through its Last-flagged byte.
  task automatic model_order(input int start_pos);
    logic [8:0] m [N][$];
    logic [8:0] e;
    int pos = start_pos;
    int c;
    bit more;
    exp_req.delete();
    exp_byte.delete();
    for (int k = 0; k < N; k++) m[k] = q[k];
    forever begin
      c = -1;
      for (int off = 1; off <= N; off++)
        if (c < 0 && m[(pos + off) % N].size() > 0) c = (pos + off) % N;
      if (c < 0) break;
      pos  = c;
      more = 1'b1;
      while (more) begin
        e = m[c].pop_front();
        exp_req.push_back(c);
        exp_byte.push_back(e[7:0]);
`ifdef UART_TX_ARB_PKT_LOCK_EN
        more = !e[8] && (m[c].size() > 0);
`else
        more = 1'b0;
`endif
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    rb[0] = 8'h3C; rb[1] = 8'h5A; rb[2] = 8'hA5; rb[3] = 8'hC3;
    tbl[0] = '{-1, 4'b0100, 4'b0100, 8'hA5};
    tbl[1] = '{-1, 4'b1111, 4'b0001, 8'h3C};
    tbl[2] = '{ 3, 4'b1001, 4'b0001, 8'h3C};
    tbl[3] = '{ 0, 4'b1001, 4'b1000, 8'hC3};
    tbl[4] = '{ 1, 4'b0011, 4'b0001, 8'h3C};
    tbl[5] = '{ 2, 4'b0110, 4'b0010, 8'h5A};
    tbl[6] = '{ 1, 4'b1110, 4'b0100, 8'hA5};
    tbl[7] = '{ 3, 4'b1000, 4'b1000, 8'hC3};
    tbl[8] = '{ 2, 4'b0001, 4'b0001, 8'h3C};

    // arbitration decisions from a known pointer
    for (int v = 0; v < 9; v++) begin
      do_reset();
      if (tbl[v].prev >= 0) begin
        q[tbl[v].prev].push_back(9'h177);
        run_engine(1, 200);
      end
      for (int k = 0; k < N; k++) begin
        req_valid[k]       = tbl[v].mask[k];
        req_byte[k*8 +: 8] = rb[k];
        req_last[k]        = 1'b1;
      end
      step();
      check("tbl_grant", {28'd0, grant}, {28'd0, tbl[v].exp_grant});
      check("tbl_ack", {28'd0, ack}, {28'd0, tbl[v].exp_grant});
      check("tbl_byte", {24'd0, tx_byte}, {24'd0, tbl[v].exp_byte});
      check("tbl_ready", {31'd0, tx_ready}, 32'd1);
    end

    // single byte timing, Done ignored in LAUNCH, re-ack two cycles after Done
    do_reset();
    req_last = '1;
    req_valid[2] = 1'b1;
    req_byte[23:16] = 8'hA5;
    step();
    check("sb_ack", {28'd0, ack}, 32'b0100);
    check("sb_grant", {28'd0, grant}, 32'b0100);
    check("sb_byte", {24'd0, tx_byte}, 32'hA5);
    check("sb_ready", {31'd0, tx_ready}, 32'd1);
    check("sb_busy", {31'd0, busy}, 32'd1);
    req_valid[2] = 1'b0;
    tx_done = 1'b1;
    step();
    check("sb_ack_pulse", {28'd0, ack}, 32'd0);
    check("sb_done_in_launch", {31'd0, tx_ready}, 32'd1);
    tx_done   = 1'b0;
    tx_active = 1'b1;
    step();
    check("sb_ready_drop", {31'd0, tx_ready}, 32'd0);
    check("sb_busy_hold", {31'd0, busy}, 32'd1);
    step();
    tx_active = 1'b0;
    tx_done   = 1'b1;
    req_valid[0] = 1'b1;
    req_byte[7:0] = 8'h42;
    step();
    tx_done = 1'b0;
    check("sb_idle_busy", {31'd0, busy}, 32'd0);
    check("sb_idle_grant", {28'd0, grant}, 32'd0);
    check("sb_idle_noack", {28'd0, ack}, 32'd0);
    step();
    check("sb_next_ack", {28'd0, ack}, 32'b0001);
    check("sb_next_byte", {24'd0, tx_byte}, 32'h42);

    // all four valid: 0,1,2,3 then 0 again
    do_reset();
    q[0].push_back(9'h110); q[0].push_back(9'h114);
    q[1].push_back(9'h111);
    q[2].push_back(9'h112);
    q[3].push_back(9'h113);
    exp_req  = '{0, 1, 2, 3, 0};
    exp_byte = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
    run_engine(5, 400);
    compare_lists("round");

    // packet lock vs per-byte interleave
    do_reset();
    q[0].push_back(9'h177);
    run_engine(1, 200);
    q[1].push_back(9'h001); q[1].push_back(9'h002); q[1].push_back(9'h103);
    q[0].push_back(9'h1E0); q[0].push_back(9'h1E1);
`ifdef UART_TX_ARB_PKT_LOCK_EN
    exp_req  = '{1, 1, 1, 0, 0};
    exp_byte = '{8'h01, 8'h02, 8'h03, 8'hE0, 8'hE1};
`else
    exp_req  = '{1, 0, 1, 0, 1};
    exp_byte = '{8'h01, 8'hE0, 8'h02, 8'hE1, 8'h03};
`endif
    run_engine(5, 400);
    compare_lists("pkt");

    // asynchronous reset while BUSY, then requester 0 has priority
    do_reset();
    req_last = '1;
    req_valid[2] = 1'b1;
    req_byte[23:16] = 8'h5A;
    step();
    req_valid = '0;
    tx_active = 1'b1;
    step();
    check("rst_pre_busy", {31'd0, busy}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_async", {ack, grant, tx_byte, tx_ready, busy}, '0);
    tx_active = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < N; k++) begin
      req_valid[k] = 1'b1;
      req_byte[k*8 +: 8] = rb[k];
    end
    step();
    check("rst_prio", {28'd0, grant}, 32'b0001);
    check("rst_prio_byte", {24'd0, tx_byte}, 32'h3C);

    // randomized traffic against the reference order
    for (int it = 0; it < 8; it++) begin
      do_reset();
      nb = 0;
      for (int k = 0; k < N; k++) begin
        int len = $urandom_range(0, 4);
        for (int j = 0; j < len; j++) begin
          logic [8:0] e;
          e[7:0] = 8'($urandom);
          e[8]   = (j == len - 1) ? 1'b1 : 1'($urandom_range(0, 1));
          q[k].push_back(e);
          nb++;
        end
      end
      model_order(N - 1);
      run_engine(nb, 1500);
      compare_lists("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
